reaction_game_ctrl: RTL

Parametrised successor to the board's fixed five-state reaction-timer sequencer. Runs a multi-round game and draws each arm delay from an LFSR. Detects false starts, saturates at a timeout, averages the rounds and holds a best score. Emits binary results plus a state code; the existing bcd_decoder instances at board top format these for the HEX displays.

---
 rtl/reaction_pkg.sv | 25 ++
 rtl/reaction_game_ctrl_button_sync_edge.sv | 31 +++
 rtl/reaction_game_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction game controller.
package reaction_pkg;

  // State codes double as the HEX5 display digit.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ARMED  = 4'd1,
    ST_TIMING = 4'd2,
    ST_SHOW   = 4'd3,
    ST_RESULT = 4'd4,
    ST_FAULT  = 4'd5
  } state_e;

  // Button synchroniser depth.
  localparam int SYNC_STAGES = 2;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (right-shifting form: bits 0,2,3,5).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/reaction_game_ctrl_button_sync_edge.sv
// Two-flop synchroniser for an active-low raw button, followed by a
// registered falling-edge detector: one pulse per press, however long held.
module button_sync_edge
  import reaction_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press_p
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   press_q;

  // Synchronise, remember previous level, pulse on the high-to-low transition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_n};
      prev_q  <= sync_q[SYNC_STAGES-1];
      press_q <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign press_p = press_q;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Multi-round reaction timer: random arm delay, false-start detection,
// timeout saturation, per-game average and best-score tracking.
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int TICK_DIV      = 50000,
  parameter int TIME_W        = 14,
  parameter int ROUNDS        = 4,
  parameter int MIN_DELAY_MS  = 1000,
  parameter int DELAY_SPAN_MS = 2048,
  parameter int TIMEOUT_MS    = 9999,
  parameter int SHOW_MS       = 1500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_n,
  input  logic              react_n,
  output logic [3:0]        state,
  output logic              go_led,
  output logic [3:0]        round_idx,
  output logic [TIME_W-1:0] disp_value,
  output logic              disp_blank,
  output logic [TIME_W-1:0] best_ms,
  output logic              new_best,
  output logic [7:0]        false_starts
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SUM_W  = TIME_W + 4;
  localparam int RND_SH = $clog2(ROUNDS);
  localparam int DLY_W  = $clog2(MIN_DELAY_MS + DELAY_SPAN_MS);
  localparam logic [15:0] SPAN_MASK = 16'(DELAY_SPAN_MS - 1);

  logic start_p, react_p;

  button_sync_edge u_start_sync (.clk(clk), .reset(reset), .btn_n(start_n), .press_p(start_p));
  button_sync_edge u_react_sync (.clk(clk), .reset(reset), .btn_n(react_n), .press_p(react_p));

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic [TIME_W-1:0] ms_q, ms_d;       // ticks since entry of the current state
  logic [TIME_W-1:0] last_q, last_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [3:0]        round_q, round_d;
  logic [TIME_W-1:0] best_q, best_d;
  logic              new_best_q, new_best_d;
  logic [7:0]        fs_q, fs_d;

  logic              tick;
  logic              hold_done;
  logic              timeout_hit;
  logic [4:0]        round_inc;
  logic [TIME_W-1:0] avg;

  assign tick        = (pre_q == PRE_W'(TICK_DIV - 1));
  assign hold_done   = tick && (ms_q == TIME_W'(SHOW_MS - 1));
  assign timeout_hit = tick && (ms_q == TIME_W'(TIMEOUT_MS - 1));
  assign round_inc   = {1'b0, round_q} + 5'd1;
  assign avg         = TIME_W'(sum_q >> RND_SH);

  // State and datapath registers; the LFSR free-runs outside reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= LFSR_SEED;
      pre_q      <= '0;
      delay_q    <= '0;
      ms_q       <= '0;
      last_q     <= '0;
      sum_q      <= '0;
      round_q    <= '0;
      best_q     <= '1;
      new_best_q <= 1'b0;
      fs_q       <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_step(lfsr_q);
      pre_q      <= pre_d;
      delay_q    <= delay_d;
      ms_q       <= ms_d;
      last_q     <= last_d;
      sum_q      <= sum_d;
      round_q    <= round_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
      fs_q       <= fs_d;
    end
  end

  // Next-state and datapath updates for the game sequencer.
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    ms_d       = ms_q;
    last_d     = last_q;
    sum_d      = sum_q;
    round_d    = round_q;
    best_d     = best_q;
    new_best_d = 1'b0;
    fs_d       = fs_q;

    case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (start_p) begin
          state_d = ST_ARMED;
          round_d = '0;
          sum_d   = '0;
          fs_d    = '0;
        end
      end
      ST_ARMED: begin
        // A press before GO is a false start, even on the expiry cycle.
        if (react_p) begin
          state_d = ST_FAULT;
          if (fs_q != 8'hFF) fs_d = fs_q + 8'd1;
        end else if (delay_q == '0) begin
          state_d = ST_TIMING;
        end else if (tick) begin
          delay_d = delay_q - DLY_W'(1);
        end
      end
      ST_TIMING: begin
        // Timeout wins over a press arriving on the same cycle.
        if (timeout_hit) begin
          last_d  = TIME_W'(TIMEOUT_MS);
          sum_d   = sum_q + SUM_W'(TIMEOUT_MS);
          state_d = ST_SHOW;
        end else if (react_p) begin
          last_d  = ms_q;
          sum_d   = sum_q + SUM_W'(ms_q);
          state_d = ST_SHOW;
        end else if (tick) begin
          ms_d = ms_q + TIME_W'(1);
        end
      end
      ST_SHOW: begin
        if (start_p || hold_done) begin
          round_d = round_inc[3:0];
          if (round_inc == 5'(ROUNDS)) begin
            state_d = ST_RESULT;
            if (avg < best_q) begin
              best_d     = avg;
              new_best_d = 1'b1;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end else if (tick) begin
          ms_d = ms_q + TIME_W'(1);
        end
      end
      ST_FAULT: begin
        if (hold_done) begin
          state_d = ST_ARMED;
        end else if (tick) begin
          ms_d = ms_q + TIME_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every state entry restarts the ms timebase; ARMED also draws a new delay.
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    if (state_d != state_q) begin
      pre_d = '0;
      ms_d  = '0;
      if (state_d == ST_ARMED) begin
        delay_d = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q & SPAN_MASK);
      end
    end
  end

  // Display selection per state.
  always_comb begin
    disp_value = '0;
    disp_blank = 1'b0;
    case (state_q)
      ST_IDLE, ST_ARMED: disp_blank = 1'b1;
      ST_TIMING:         disp_value = ms_q;
      ST_SHOW:           disp_value = last_q;
      ST_RESULT:         disp_value = avg;
      default:           disp_value = '0;
    endcase
  end

  assign state        = state_q;
  assign go_led       = (state_q == ST_TIMING);
  assign round_idx    = round_q;
  assign best_ms      = best_q;
  assign new_best     = new_best_q;
  assign false_starts = fs_q;

endmodule
